fetch_align_buffer: RTL
=======================

// Module: fetch_align_buffer
// PURPOSE
//  Parametrised halfword-granular instruction buffer between the fetch unit and the decoder.
//  Accepts word-aligned 32-bit fetch words and re-aligns them into whole instructions,
//  including 16-bit RVC and 32-bit instructions straddling word boundaries.
//  Presents one instruction plus its PC per valid/ready handshake. Flush/redirect support for jumps.
// PARAMETERS
//  DEPTH    4             buffer capacity in halfwords; power of 2, >= 4
//  RESET_PC 32'h0000_0000 PC of the first instruction after reset
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous reset, active-high
//  flush           in   1   redirect: discard buffer contents, restart at flush_pc
//  flush_pc        in   32  new PC on flush; bit 0 ignored
//  fetch_valid     in   1   fetch_data is valid this cycle
//  fetch_ready     out  1   buffer can accept a word this cycle
//  fetch_data      in   32  word-aligned fetch data, little-endian halfwords
//  out_valid       out  1   out_instr/out_pc hold a complete instruction
//  out_ready       in   1   decoder consumes the instruction
//  out_instr       out  32  instruction; RVC as {16'b0, hw}
//  out_pc          out  32  PC of out_instr
//  out_compressed  out  1   out_instr is a 16-bit instruction
//  out_illegal     out  1   instruction is architecturally illegal at this stage
// BEHAVIOUR
//  - Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
//  - Storage: DEPTH x 16-bit ring with wr_ptr and rd_ptr (log2 DEPTH bits, wrap mod DEPTH).
//    count ranges 0..DEPTH. Also has skip_low flag and pc register.
//  - Reset: count=0, pointers=0, pc=RESET_PC, skip_low=RESET_PC[1].
//    Outputs: fetch_ready=0 during the reset cycle; out_valid=0, out_compressed=0, out_illegal=0.
//  - fetch_ready = !flush && count <= DEPTH-2. It is a function of registered count only.
//    A same-cycle pop does not raise it.
//  - Push on fetch_valid && fetch_ready:
//    - skip_low=1: write fetch_data[31:16] only (+1), then clear skip_low.
//    - Otherwise: write [15:0] then [31:16] (+2).
//  - Head hw0=buf[rd_ptr], hw1=buf[rd_ptr+1].
//    - hw0[1:0]!=2'b11: compressed; out_valid=count>=1; out_instr={16'b0,hw0}; pop 1 hw; pc+=2.
//    - Otherwise: out_valid=count>=2; out_instr={hw1,hw0}; pop 2 hw; pc+=4.
//  - Output is combinational from buffer state. A word accepted in cycle N is visible at N+1
//    (latency 1). No bypass.
//  - Pop occurs on out_valid && out_ready.
//  - When out_valid=0, out_instr/out_compressed/out_illegal are don't-care. out_pc is always pc.
//  - Simultaneous push and pop in one cycle: count += pushed - popped. This must work at
//    count=DEPTH-2 and around pointer wrap.
//  - A straddling 32-bit instruction (hw0 is the last hw of a word) waits with out_valid=0
//    until the next word arrives.
//  - flush has top priority after reset: count=0, pointers=0, pc={flush_pc[31:1],1'b0},
//    skip_low=flush_pc[1]. Any push or pop in the flush cycle is discarded.
//    out_valid=0 in the cycle after the flush.
//  - Upstream must supply the word containing flush_pc next.
//  - out_illegal=1 when out_valid and out_instr==32'h0000_0000 (RVC all-zero encoding).
//    The instruction is still popped normally; the decoder raises the trap.
//  - Upstream must never present fetch_valid while fetch_ready=0 expecting acceptance.
//    Data is taken only on the handshake.
// CONFIGURATION
//  FETCH_ALIGN_C_EXT_EN defined:
//    - Behaviour as above (RVC supported).
//  FETCH_ALIGN_C_EXT_EN undefined:
//    - out_compressed tied to 0.
//    - Every instruction is {hw1,hw0}: out_valid requires count>=2; pop 2; pc+=4.
//    - out_illegal = out_valid && hw0[1:0]!=2'b11.
//    - skip_low is forced 0; flush_pc[1] is ignored (pc={flush_pc[31:2],2'b00}).
// TESTING
//  - Reset, RESET_PC=0. Push 32'h0013_0513 (addi).
//    -> next cycle out_valid=1, out_instr=32'h0013_0513, out_pc=0, out_compressed=0; pop -> out_pc=4.
//  - Push 32'h4505_4501 (two c.li).
//    -> 32'h0000_4501 @pc0, then 32'h0000_4505 @pc2; out_compressed=1 for both.
//  - Push 32'h0513_4501 then 32'hXXXX_0013.
//    -> c.li @pc0; out_valid=0 until the 2nd word; then 32'h0013_0513 @pc2 (straddle).
//  - Hold out_ready=0 and stream words.
//    -> fetch_ready drops at count=DEPTH-1/DEPTH and no data is lost.
//    Then run out_ready=1 continuously for 3*DEPTH halfwords across pointer wrap with
//    simultaneous push/pop -> in-order output.
//  - Fill the buffer, then flush with flush_pc=32'h0000_0102 and push 32'h4505_0001.
//    -> old data is gone; out_instr=32'h0000_4505 @pc 0x102. The low half is skipped.
//  - Push 32'h0000_0000 -> out_illegal=1, out_compressed=1, pc+=2.
//    With FETCH_ALIGN_C_EXT_EN undefined: out_illegal=1, out_compressed=0, pc+=4.

Source files
------------

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: halfword ring re-aligning fetch words into RVC/32-bit instructions; RVC enabled by FETCH_ALIGN_C_EXT_EN
module fetch_align_buffer #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed,
  output logic        out_illegal
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, push_n, pop_n;
  logic [15:0]   hw0, hw1;
  logic          skip_low, compressed, push, pop;
  logic [31:0]   pc;
  always_comb begin
    hw0 = mem[rd_ptr];
    hw1 = mem[rd_ptr + AW'(1)];
`ifdef FETCH_ALIGN_C_EXT_EN
    compressed = hw0[1:0] != 2'b11;
`else
    compressed = 1'b0;
`endif
    out_valid = !reset && count >= (compressed ? (AW+1)'(1) : (AW+1)'(2));
    out_instr = compressed ? {16'h0, hw0} : {hw1, hw0};
    out_compressed = out_valid && compressed;
`ifdef FETCH_ALIGN_C_EXT_EN
    out_illegal = out_valid && out_instr == 32'h0;
`else
    out_illegal = out_valid && hw0[1:0] != 2'b11;
`endif
    out_pc = pc;
    fetch_ready = !reset && !flush && count <= (AW+1)'(DEPTH-2);
    push = fetch_valid && fetch_ready;
    pop = out_valid && out_ready;
    push_n = push ? (skip_low ? (AW+1)'(1) : (AW+1)'(2)) : '0;
    pop_n = pop ? (compressed ? (AW+1)'(1) : (AW+1)'(2)) : '0;
  end
  // push is already masked by reset and flush through fetch_ready
  always_ff @(posedge clk)
    if (push) begin
      mem[wr_ptr] <= skip_low ? fetch_data[31:16] : fetch_data[15:0];
      if (!skip_low) mem[wr_ptr + AW'(1)] <= fetch_data[31:16];
    end
  always_ff @(posedge clk)
    if (reset || flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
`ifdef FETCH_ALIGN_C_EXT_EN
      pc <= reset ? RESET_PC : flush_pc & 32'hFFFF_FFFE;
      skip_low <= reset ? RESET_PC[1] : flush_pc[1];
`else
      pc <= reset ? RESET_PC : flush_pc & 32'hFFFF_FFFC;
      skip_low <= 1'b0;
`endif
    end else begin
      count <= count + push_n - pop_n;
      wr_ptr <= wr_ptr + push_n[AW-1:0];
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      pc <= pc + (pop ? (compressed ? 32'd2 : 32'd4) : 32'd0);
      if (push) skip_low <= 1'b0;
    end
endmodule
